// File: rtl/imul_pkg.sv
// Shared types and constants for integer multiplier request messages.
package imul_pkg;

  localparam int IMUL_OPND_NBITS = 32;
  localparam int IMUL_REQ_NBITS  = 2 * IMUL_OPND_NBITS;

  typedef struct packed {
    logic [IMUL_OPND_NBITS-1:0] a;
    logic [IMUL_OPND_NBITS-1:0] b;
  } imul_req_msg_t;

  // Pointer width for a queue of n entries; a single-entry queue still gets one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imul_req_queue_if.sv
// Enqueue/dequeue val/rdy bundle of the multiplier request queue.
interface imul_req_queue_if
  import imul_pkg::*;
#(
  parameter int p_nbits       = IMUL_REQ_NBITS,
  parameter int p_num_entries = 4
);
  localparam int CNT_W = $clog2(p_num_entries + 1);

  logic               enq_val;
  logic               enq_rdy;
  logic [p_nbits-1:0] enq_msg;
  logic               deq_val;
  logic               deq_rdy;
  logic [p_nbits-1:0] deq_msg;
  logic [CNT_W-1:0]   num_free_entries;

  modport master (
    output enq_val, enq_msg, deq_rdy,
    input  enq_rdy, deq_val, deq_msg, num_free_entries
  );

  modport slave (
    input  enq_val, enq_msg, deq_rdy,
    output enq_rdy, deq_val, deq_msg, num_free_entries
  );

endinterface

// File: rtl/imul_req_queue_ctrl.sv
// Pointer/count bookkeeping for the request queue; flags come from registered state only.
module imul_req_queue_ctrl
  import imul_pkg::*;
#(
  parameter int  p_num_entries = 4,
  localparam int PTR_W = ptr_width(p_num_entries),
  localparam int CNT_W = $clog2(p_num_entries + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  input  logic             deq_rdy,
  output logic             enq_rdy,
  output logic             deq_val,
  output logic [CNT_W-1:0] num_free_entries,
  output logic             wen,
  output logic [PTR_W-1:0] waddr,
  output logic [PTR_W-1:0] raddr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(p_num_entries - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(p_num_entries);

  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic [CNT_W-1:0] count;
  logic             enq_go;
  logic             deq_go;

  assign enq_rdy          = (count != FULL);
  assign deq_val          = (count != '0);
  assign num_free_entries = FULL - count;
  assign enq_go           = enq_val && enq_rdy;
  assign deq_go           = deq_val && deq_rdy;
  assign wen              = enq_go;
  assign waddr            = enq_ptr;
  assign raddr            = deq_ptr;

  // Explicit wrap compare so non-power-of-two depths never index past the last slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (enq_go) enq_ptr <= (enq_ptr == LAST) ? '0 : enq_ptr + PTR_W'(1);
      if (deq_go) deq_ptr <= (deq_ptr == LAST) ? '0 : deq_ptr + PTR_W'(1);
      case ({enq_go, deq_go})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count <= FULL);
      assert (!(deq_go && !enq_go && count == '0));
      assert (enq_ptr <= LAST && deq_ptr <= LAST);
      assert (!$isunknown(enq_val));
      assert (!$isunknown(deq_rdy));
    end
  end

endmodule

// File: rtl/imul_req_queue.sv
// Normal (non-bypass) val/rdy FIFO holding {a, b} requests ahead of the iterative multiplier.
module imul_req_queue
  import imul_pkg::*;
#(
  parameter int p_nbits       = IMUL_REQ_NBITS,
  parameter int p_num_entries = 4
) (
  input  logic           clk,
  input  logic           reset,
  imul_req_queue_if.slave q
);

  localparam int PTR_W = ptr_width(p_num_entries);

  logic               wen;
  logic [PTR_W-1:0]   waddr;
  logic [PTR_W-1:0]   raddr;
  logic [p_nbits-1:0] storage [p_num_entries];

  imul_req_queue_ctrl #(
    .p_num_entries (p_num_entries)
  ) ctrl (
    .clk              (clk),
    .reset            (reset),
    .enq_val          (q.enq_val),
    .deq_rdy          (q.deq_rdy),
    .enq_rdy          (q.enq_rdy),
    .deq_val          (q.deq_val),
    .num_free_entries (q.num_free_entries),
    .wen              (wen),
    .waddr            (waddr),
    .raddr            (raddr)
  );

  // Data storage carries no reset; validity is tracked entirely by the ctrl count.
  always_ff @(posedge clk) begin
    if (wen) storage[waddr] <= q.enq_msg;
  end

  assign q.deq_msg = storage[raddr];

endmodule

// File: tb/tb_imul_req_queue.sv
// Directed bench for imul_req_queue at depth 4 and depth 3.
module tb_imul_req_queue;
  import imul_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  imul_req_queue_if #(.p_nbits(64), .p_num_entries(4)) q4 ();
  imul_req_queue_if #(.p_nbits(64), .p_num_entries(3)) q3 ();

  imul_req_queue #(.p_nbits(64), .p_num_entries(4)) dut4 (.clk(clk), .reset(reset), .q(q4));
  imul_req_queue #(.p_nbits(64), .p_num_entries(3)) dut3 (.clk(clk), .reset(reset), .q(q3));

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [31:0] b);
    imul_req_msg_t m;
    m.a = a;
    m.b = b;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (q4.enq_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_enq_rdy: got %b want 1", q4.enq_rdy); end
    n_cmp++; if (q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL rst_deq_val: got %b want 0", q4.deq_val); end
    n_cmp++; if (q4.num_free_entries !== 3'd4) begin n_bad++; $display("FAIL rst_nfree: got %0d want 4", q4.num_free_entries); end
    n_cmp++; if (q3.num_free_entries !== 2'd3) begin n_bad++; $display("FAIL rst_nfree3: got %0d want 3", q3.num_free_entries); end
    step();
    reset = 1'b1;
    step();
    n_cmp++; if (q4.enq_rdy !== 1'b1 || q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL idle_flags: got rdy=%b val=%b want 1 0", q4.enq_rdy, q4.deq_val); end
    n_cmp++; if (q4.num_free_entries !== 3'd4) begin n_bad++; $display("FAIL idle_nfree: got %0d want 4", q4.num_free_entries); end
  endtask

  task automatic test_single();
    q4.enq_val = 1'b1;
    q4.enq_msg = mk(32'd3, 32'd4);
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass: got %b want 0", q4.deq_val); end
    step();
    q4.enq_val = 1'b0;
    n_cmp++; if (q4.deq_val !== 1'b1) begin n_bad++; $display("FAIL single_deq_val: got %b want 1", q4.deq_val); end
    n_cmp++; if (q4.deq_msg !== 64'h00000003_00000004) begin n_bad++; $display("FAIL single_msg: got %h want 0000000300000004", q4.deq_msg); end
    n_cmp++; if (q4.num_free_entries !== 3'd3) begin n_bad++; $display("FAIL single_nfree: got %0d want 3", q4.num_free_entries); end
    q4.deq_rdy = 1'b1;
    step();
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %b want 0", q4.deq_val); end
    n_cmp++; if (q4.num_free_entries !== 3'd4) begin n_bad++; $display("FAIL single_nfree_end: got %0d want 4", q4.num_free_entries); end
  endtask

  task automatic test_empty_enq_deq();
    q4.enq_val = 1'b1;
    q4.enq_msg = mk(32'd0, 32'h77);
    q4.deq_rdy = 1'b1;
    step();
    q4.enq_val = 1'b0;
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.num_free_entries !== 3'd3) begin n_bad++; $display("FAIL empty_sim_nfree: got %0d want 3", q4.num_free_entries); end
    n_cmp++; if (q4.deq_msg !== mk(32'd0, 32'h77)) begin n_bad++; $display("FAIL empty_sim_msg: got %h want 77", q4.deq_msg); end
    q4.deq_rdy = 1'b1;
    step();
    q4.deq_rdy = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      q4.enq_val = 1'b1;
      q4.enq_msg = mk(32'd0, 32'(i));
      n_cmp++; if (q4.enq_rdy !== 1'b1) begin n_bad++; $display("FAIL fill_rdy_%0d: got %b want 1", i, q4.enq_rdy); end
      step();
    end
    q4.enq_msg = mk(32'd0, 32'd5);
    n_cmp++; if (q4.enq_rdy !== 1'b0) begin n_bad++; $display("FAIL full_rdy: got %b want 0", q4.enq_rdy); end
    n_cmp++; if (q4.num_free_entries !== 3'd0) begin n_bad++; $display("FAIL full_nfree: got %0d want 0", q4.num_free_entries); end
    step();
    n_cmp++; if (q4.enq_rdy !== 1'b0 || q4.deq_msg !== mk(32'd0, 32'd1)) begin n_bad++; $display("FAIL full_hold: got rdy=%b msg=%h want 0 1", q4.enq_rdy, q4.deq_msg); end
    q4.deq_rdy = 1'b1;
    step();
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.enq_rdy !== 1'b1 || q4.num_free_entries !== 3'd1) begin n_bad++; $display("FAIL full_freed: got rdy=%b nfree=%0d want 1 1", q4.enq_rdy, q4.num_free_entries); end
    step();
    q4.enq_val = 1'b0;
    n_cmp++; if (q4.num_free_entries !== 3'd0) begin n_bad++; $display("FAIL fifth_taken: got %0d want 0", q4.num_free_entries); end
    q4.deq_rdy = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      n_cmp++; if (q4.deq_val !== 1'b1 || q4.deq_msg !== mk(32'd0, 32'(i))) begin n_bad++; $display("FAIL drain_%0d: got val=%b msg=%h want 1 %0d", i, q4.deq_val, q4.deq_msg, i); end
      step();
    end
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", q4.deq_val); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    q4.enq_val = 1'b1;
    q4.enq_msg = mk(32'd0, 32'h0E);
    step();
    q4.enq_msg = mk(32'd0, 32'h0F);
    step();
    q4.deq_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q4.enq_msg = mk(32'd0, 32'h10 + 32'(i));
      want = 32'h0E + 32'(i);
      n_cmp++; if (q4.num_free_entries !== 3'd2) begin n_bad++; $display("FAIL b2b_nfree_%0d: got %0d want 2", i, q4.num_free_entries); end
      n_cmp++; if (q4.deq_msg !== mk(32'd0, want)) begin n_bad++; $display("FAIL b2b_msg_%0d: got %h want %h", i, q4.deq_msg, want); end
      step();
    end
    q4.enq_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      want = 32'h18 + 32'(i);
      n_cmp++; if (q4.deq_val !== 1'b1 || q4.deq_msg !== mk(32'd0, want)) begin n_bad++; $display("FAIL b2b_tail_%0d: got val=%b msg=%h want 1 %h", i, q4.deq_val, q4.deq_msg, want); end
      step();
    end
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", q4.deq_val); end
  endtask

  task automatic test_wrap3();
    logic [31:0] pat;
    int sent = 0;
    int recv = 0;
    int cnt  = 0;
    logic eg, dg;
    pat = 32'b0110_1100_1010_0011_1001_0110_0100_1101;
    for (int cyc = 0; cyc < 64 && recv < 7; cyc++) begin
      q3.enq_val = (sent < 7);
      q3.enq_msg = mk(32'd0, 32'hC0 + 32'(sent));
      q3.deq_rdy = (cyc >= 32) ? 1'b1 : pat[cyc];
      n_cmp++; if (q3.enq_rdy !== (cnt != 3) || q3.deq_val !== (cnt != 0)) begin n_bad++; $display("FAIL wrap_flags_c%0d: got rdy=%b val=%b for count %0d", cyc, q3.enq_rdy, q3.deq_val, cnt); end
      eg = q3.enq_val && q3.enq_rdy;
      dg = q3.deq_val && q3.deq_rdy;
      if (dg) begin
        n_cmp++; if (q3.deq_msg !== mk(32'd0, 32'hC0 + 32'(recv))) begin n_bad++; $display("FAIL wrap_order_%0d: got %h want %h", recv, q3.deq_msg, 32'hC0 + 32'(recv)); end
        recv++;
      end
      if (eg) sent++;
      cnt = cnt + int'(eg) - int'(dg);
      step();
    end
    q3.enq_val = 1'b0;
    q3.deq_rdy = 1'b0;
    n_cmp++; if (recv != 7) begin n_bad++; $display("FAIL wrap_timeout: got %0d messages want 7", recv); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      q4.enq_val = 1'b1;
      q4.enq_msg = mk(32'd0, 32'hA0 + 32'(i));
      step();
    end
    q4.enq_msg = mk(32'd0, 32'hA4);
    q4.deq_rdy = 1'b1;
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (q4.deq_val !== 1'b0 || q4.enq_rdy !== 1'b1) begin n_bad++; $display("FAIL async_rst_flags: got val=%b rdy=%b want 0 1", q4.deq_val, q4.enq_rdy); end
    n_cmp++; if (q4.num_free_entries !== 3'd4) begin n_bad++; $display("FAIL async_rst_nfree: got %0d want 4", q4.num_free_entries); end
    step();
    reset = 1'b1;
    q4.enq_val = 1'b0;
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.num_free_entries !== 3'd4 || q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL post_rst: got nfree=%0d val=%b want 4 0", q4.num_free_entries, q4.deq_val); end
    q4.enq_val = 1'b1;
    q4.enq_msg = mk(32'd0, 32'hAB);
    step();
    q4.enq_val = 1'b0;
    n_cmp++; if (q4.deq_val !== 1'b1 || q4.deq_msg !== mk(32'd0, 32'hAB)) begin n_bad++; $display("FAIL post_rst_first: got val=%b msg=%h want 1 ab", q4.deq_val, q4.deq_msg); end
    n_cmp++; if (q4.num_free_entries !== 3'd3) begin n_bad++; $display("FAIL post_rst_nfree: got %0d want 3", q4.num_free_entries); end
    q4.deq_rdy = 1'b1;
    step();
    q4.deq_rdy = 1'b0;
    n_cmp++; if (q4.deq_val !== 1'b0) begin n_bad++; $display("FAIL post_rst_empty: got %b want 0", q4.deq_val); end
  endtask

  initial begin
    reset      = 1'b0;
    q4.enq_val = 1'b0;
    q4.enq_msg = '0;
    q4.deq_rdy = 1'b0;
    q3.enq_val = 1'b0;
    q3.enq_msg = '0;
    q3.deq_rdy = 1'b0;
    test_reset();
    test_single();
    test_empty_enq_deq();
    test_fill();
    test_back_to_back();
    test_wrap3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
